// File: rtl/controle_cifra_pkg.sv
// rtl/controle_cifra_pkg.sv - shared types, constants and byte-index helpers for the AES-128 controller
package controle_cifra_pkg;

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      RODADA = 2'd1,
      SAIDA  = 2'd2
   } fase_t;

   localparam logic [3:0] NUM_RODADAS  = 4'd10;
   localparam logic [7:0] RCON_INICIAL = 8'h01;

   localparam int NUM_BYTES = 16;
   localparam int LINHAS    = 4;
   localparam int COLUNAS   = 4;

   // Byte k sits at bits [127-8k : 120-8k]; row = k/4, column = k%4.
   function automatic int lsb_byte(int k);
      return 8 * (NUM_BYTES - 1 - k);
   endfunction

   function automatic int indice(int linha, int coluna);
      return COLUNAS * linha + coluna;
   endfunction

   function automatic logic [31:0] le_coluna(logic [127:0] s, int c);
      return {s[lsb_byte(c) +: 8], s[lsb_byte(c + 4) +: 8],
              s[lsb_byte(c + 8) +: 8], s[lsb_byte(c + 12) +: 8]};
   endfunction

   function automatic logic [7:0] xtime(logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p;
      logic [7:0] m;
      p = '0;
      m = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ m;
         m = xtime(m);
      end
      return p;
   endfunction

endpackage

// File: rtl/controle_cifra_if.sv
// rtl/controle_cifra_if.sv - job/result handshake bundle of the AES-128 controller
interface controle_cifra_if;
   import controle_cifra_pkg::*;

   logic         entrada_valida;
   logic         entrada_pronta;
   logic [127:0] bloco;
   logic [127:0] chave;
   logic         saida_valida;
   logic         saida_pronta;
   logic [127:0] saida;
   logic         ocupado;
   logic [3:0]   rodada;

   modport master (
      output entrada_valida, bloco, chave, saida_pronta,
      input  entrada_pronta, saida_valida, saida, ocupado, rodada
   );

   modport slave (
      input  entrada_valida, bloco, chave, saida_pronta,
      output entrada_pronta, saida_valida, saida, ocupado, rodada
   );

endinterface

// File: rtl/caixa_s.sv
// rtl/caixa_s.sv - combinational AES S-box (GF(2^8) inverse followed by the affine map)
module caixa_s
   import controle_cifra_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] s
);

   logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;

   // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs.
   always_comb begin
      x2   = gf_mul(a, a);
      x4   = gf_mul(x2, x2);
      x8   = gf_mul(x4, x4);
      x16  = gf_mul(x8, x8);
      x32  = gf_mul(x16, x16);
      x64  = gf_mul(x32, x32);
      x128 = gf_mul(x64, x64);
      inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                    gf_mul(gf_mul(x32, x64), x128));
      s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

endmodule

// File: rtl/mistura_coluna.sv
// rtl/mistura_coluna.sv - combinational MixColumns on one column, row 0 in the top byte
module mistura_coluna (
   input  logic [31:0] coluna,
   output logic [31:0] mistura
);

   function automatic logic [7:0] dobra(logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   logic [7:0] a0, a1, a2, a3;

   always_comb begin
      a0 = coluna[31:24];
      a1 = coluna[23:16];
      a2 = coluna[15:8];
      a3 = coluna[7:0];
      mistura[31:24] = dobra(a0) ^ dobra(a1) ^ a1 ^ a2 ^ a3;
      mistura[23:16] = a0 ^ dobra(a1) ^ dobra(a2) ^ a2 ^ a3;
      mistura[15:8]  = a0 ^ a1 ^ dobra(a2) ^ dobra(a3) ^ a3;
      mistura[7:0]   = dobra(a0) ^ a0 ^ a1 ^ a2 ^ dobra(a3);
   end

endmodule

// File: rtl/controle_cifra.sv
// rtl/controle_cifra.sv - AES-128 encryption controller, one full round and key step per clock
module controle_cifra
   import controle_cifra_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   controle_cifra_if.slave bus
);

   fase_t        fase, prox_fase;
   logic [127:0] estado, chave_rodada, saida_r;
   logic [7:0]   rcon;
   logic [3:0]   rodada_r;

   logic [127:0] sub_bytes, desloca, misturado, chave_prox, estado_prox;
   logic [31:0]  mc_col [COLUNAS];
   logic [31:0]  ultima_palavra, palavra_rot, sub_palavra, acum;
   logic         ultima_rodada;

   assign ultima_rodada = (rodada_r == NUM_RODADAS);

   for (genvar k = 0; k < NUM_BYTES; k++) begin : g_sub_bytes
      caixa_s u_caixa (
         .a (estado[lsb_byte(k) +: 8]),
         .s (sub_bytes[lsb_byte(k) +: 8])
      );
   end

   always_comb begin
      desloca = '0;
      for (int r = 0; r < LINHAS; r++) begin
         for (int c = 0; c < COLUNAS; c++) begin
            desloca[lsb_byte(indice(r, c)) +: 8] =
               sub_bytes[lsb_byte(indice(r, (c + r) % COLUNAS)) +: 8];
         end
      end
   end

   for (genvar c = 0; c < COLUNAS; c++) begin : g_mistura
      mistura_coluna u_mistura (
         .coluna  (le_coluna(desloca, c)),
         .mistura (mc_col[c])
      );
   end

   // Key schedule word w is column w; RotWord/SubWord act on the last column.
   assign ultima_palavra = le_coluna(chave_rodada, COLUNAS - 1);
   assign palavra_rot    = {ultima_palavra[23:0], ultima_palavra[31:24]};

   for (genvar r = 0; r < LINHAS; r++) begin : g_sub_palavra
      caixa_s u_caixa (
         .a (palavra_rot[8 * (LINHAS - 1 - r) +: 8]),
         .s (sub_palavra[8 * (LINHAS - 1 - r) +: 8])
      );
   end

   always_comb begin
      acum       = sub_palavra ^ {rcon, 24'h000000};
      chave_prox = '0;
      for (int c = 0; c < COLUNAS; c++) begin
         acum = acum ^ le_coluna(chave_rodada, c);
         for (int r = 0; r < LINHAS; r++) begin
            chave_prox[lsb_byte(indice(r, c)) +: 8] = acum[8 * (LINHAS - 1 - r) +: 8];
         end
      end
   end

   always_comb begin
      misturado = '0;
      for (int c = 0; c < COLUNAS; c++) begin
         for (int r = 0; r < LINHAS; r++) begin
            misturado[lsb_byte(indice(r, c)) +: 8] = mc_col[c][8 * (LINHAS - 1 - r) +: 8];
         end
      end
      estado_prox = (ultima_rodada ? desloca : misturado) ^ chave_prox;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fase <= OCIOSO;
      else        fase <= prox_fase;
   end

   always_comb begin
      prox_fase = fase;
      case (fase)
         OCIOSO:  if (bus.entrada_valida) prox_fase = RODADA;
         RODADA:  if (ultima_rodada)      prox_fase = SAIDA;
         SAIDA:   if (bus.saida_pronta)   prox_fase = OCIOSO;
         default: prox_fase = OCIOSO;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado       <= '0;
         chave_rodada <= '0;
         saida_r      <= '0;
         rodada_r     <= '0;
         rcon         <= RCON_INICIAL;
      end else begin
         case (fase)
            OCIOSO: begin
               if (bus.entrada_valida) begin
                  estado       <= bus.bloco ^ bus.chave;
                  chave_rodada <= bus.chave;
                  rcon         <= RCON_INICIAL;
                  rodada_r     <= 4'd1;
               end
            end
            RODADA: begin
               estado       <= estado_prox;
               chave_rodada <= chave_prox;
               rcon         <= xtime(rcon);
               if (ultima_rodada) begin
                  rodada_r <= '0;
                  saida_r  <= estado_prox;
               end else begin
                  rodada_r <= rodada_r + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.entrada_pronta = (fase == OCIOSO);
   assign bus.saida_valida   = (fase == SAIDA);
   assign bus.ocupado        = (fase == RODADA);
   assign bus.saida          = saida_r;
   assign bus.rodada         = rodada_r;

endmodule

// File: doc/controle_cifra.md
CONTROLE_CIFRA -- requirements
Module: controle_cifra

Interface
REQ-001 The block SHALL have no parameters; it is fixed to AES-128 encryption with 10 rounds.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 entrada_valida  in  1  bloco/chave valid.
REQ-005 entrada_pronta  out  1  block accepts a new job.
REQ-006 bloco  in  128  plaintext state.
REQ-007 chave  in  128  cipher key.
REQ-008 saida_valida  out  1  saida holds a finished ciphertext.
REQ-009 saida_pronta  in  1  consumer accepts saida.
REQ-010 saida  out  128  ciphertext state.
REQ-011 ocupado  out  1  high in RODADA.
REQ-012 rodada  out  4  current round number, 0 when not in RODADA.

Function
REQ-013 bloco, chave and saida SHALL all use the row-major layout already used by the team's column-mix datapath:
- byte k occupies bits [127-8k : 120-8k];
- row = k/4, column = k%4;
- a column is bytes {c, c+4, c+8, c+12}.
REQ-014 The state machine SHALL have three states, with these transitions:
- OCIOSO: on entrada_valida && entrada_pronta -> RODADA;
- RODADA: after round 10 completes -> SAIDA;
- SAIDA: on saida_pronta -> OCIOSO.
REQ-015 entrada_pronta SHALL equal (state==OCIOSO); input values while not OCIOSO SHALL be ignored.
REQ-016 On acceptance the block SHALL:
- register estado = bloco XOR chave (initial AddRoundKey);
- register chave_rodada = chave;
- set rcon = 8'h01 and rodada = 1.
REQ-017 Each RODADA cycle SHALL perform one full round: SubBytes, ShiftRows, MixColumns, then AddRoundKey with the next expanded key.
- ShiftRows rotates row r left by r bytes.
- MixColumns follows FIPS-197 with reduction polynomial 0x11B.
REQ-018 Round 10 SHALL skip MixColumns.
REQ-019 The next round key SHALL be expanded on the fly in the same cycle per FIPS-197 (RotWord, SubWord, XOR rcon).
- Word w of a key is column w in the REQ-013 layout.
- rcon SHALL advance by xtime each round (01,02,04,...,80,1B,36).
REQ-020 rodada SHALL increment 1..10 while in RODADA.
REQ-021 Latency: if acceptance is at edge E0, round n SHALL complete at edge En and saida_valida SHALL rise after edge E10 (10 cycles).
REQ-022 While saida_valida && !saida_pronta, saida SHALL hold stable.
REQ-023 Each output SHALL be presented for exactly one handshake; the cycle after the handshake, entrada_pronta is 1.
REQ-024 In OCIOSO, saida SHALL retain the last ciphertext and saida_valida SHALL be 0.
REQ-025 Acceptance and output handshake SHALL never occur in the same cycle; the throughput maximum is one block per 12 cycles.

Reset
REQ-026 Assertion of rst_n=0 SHALL, immediately and asynchronously, do all of the following:
- force state OCIOSO;
- clear estado, chave_rodada, saida and rodada to 0 and rcon to 01;
- set saida_valida=0, ocupado=0, entrada_pronta=1 (after release).
REQ-027 Reset during RODADA or SAIDA SHALL abort the job with no output produced.

Structure
REQ-028 A shared package SHALL hold:
- the state enumeration (OCIOSO, RODADA, SAIDA);
- the round count 10 and initial rcon 8'h01;
- the byte-index helper constants.
REQ-029 One new sub-module caixa_s SHALL be used: the 8-bit combinational S-box, instantiated 16x for SubBytes and 4x for SubWord.
REQ-030 MixColumns SHALL reuse the team's existing combinational column-mix module unchanged.

Verification
REQ-031 The bench SHALL cover the FIPS-197 C.1 vector:
- stimulus (transposed to REQ-013 layout): plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f;
- required: saida = transposed 69c4e0d86a7b0430d8cdb78070b4c55a, with saida_valida exactly 10 cycles after acceptance.
REQ-032 The bench SHALL cover the FIPS-197 B vector:
- stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 (both transposed);
- required: transposed 3925841d02dc09fbdc118597196a0b32.
REQ-033 Back-pressure: hold saida_pronta=0 for 5 cycles after saida_valida -> saida stable, entrada_pronta=0, a new entrada_valida ignored; saida_pronta=1 -> OCIOSO next cycle.
REQ-034 Reset mid-job: pulse rst_n low at rodada=5 -> saida_valida=0, saida=0, rodada=0 immediately; a subsequent C.1 job produces the correct result.
REQ-035 Back-to-back: two jobs with saida_pronta tied 1 -> acceptances 12 cycles apart, both ciphertexts correct, rodada sequence 1..10 each.
